// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the MTM ALU serial result path.
// The PARITY state exists only when MTM_SER_PARITY_EN is defined.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TYPE,
        PAYLOAD,
`ifdef MTM_SER_PARITY_EN
        PARITY,
`endif
        STOP
    } ser_state_e;

    localparam logic BIT_START = 1'b0;
    localparam logic BIT_STOP  = 1'b1;
    localparam logic TYPE_DATA = 1'b0;
    localparam logic TYPE_CMD  = 1'b1;

    localparam logic [7:0] ERR_CTL_C9 = 8'hC9;
    localparam logic [7:0] ERR_CTL_93 = 8'h93;
    localparam logic [7:0] ERR_CTL_A5 = 8'hA5;

    function automatic logic is_err_ctl(input logic [7:0] ctl);
        return (ctl == ERR_CTL_C9) || (ctl == ERR_CTL_93) || (ctl == ERR_CTL_A5);
    endfunction

endpackage

// File: rtl/mtm_alu_bit_timer.sv
// Bit-period divider: counts 0..BIT_DIV-1 while enabled and flags the last
// cycle of each bit; cleared on packet acceptance and on reset.
module mtm_alu_bit_timer #(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] DIV_LAST = 16'(BIT_DIV - 1);

    logic [15:0] div_cnt;

    assign tick = enable && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clear || tick || !enable) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/mtm_alu_serializer_n.sv
// Serialises an ALU result (DATA_BYTES data frames + CMD frame) or an error CTL
// onto a single idle-high line. Define MTM_SER_PARITY_EN for an even-parity bit per frame.
//
//   state   | meaning
//   IDLE    | line high, ready for a packet
//   START   | start bit (0)
//   TYPE    | type bit (0 data, 1 cmd/error)
//   PAYLOAD | 8 payload bits, MSB first
//   PARITY  | even parity over type + payload (parity builds only)
//   STOP    | stop bit (1); next frame or back to IDLE
module mtm_alu_serializer_n
    import mtm_alu_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int BIT_DIV    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*DATA_BYTES-1:0] data_in,
    input  logic [7:0]              ctl_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    sout,
    output logic                    busy,
    output logic                    drop
);

    localparam int FW = $clog2(DATA_BYTES + 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(DATA_BYTES);

    ser_state_e                state, state_n;
    logic [2:0]                bit_cnt, bit_n;
    logic [FW-1:0]             frame_cnt, frame_n;
    logic [8*DATA_BYTES+7:0]   pkt_q;
    logic                      tick, active, last_stop, hs, load;
    logic                      in_err, in_legal, sout_n, cur_type;
    logic [7:0]                cur_byte;

    assign active    = (state != IDLE);
    assign busy      = active;
    assign last_stop = (state == STOP) && tick && (frame_cnt == LAST_FRAME);
    assign in_ready  = reset && ((state == IDLE) || last_stop);
    assign hs        = in_valid && in_ready;
    assign in_err    = is_err_ctl(ctl_in);
    assign in_legal  = !ctl_in[7] || in_err;
    assign load      = hs && in_legal;

    mtm_alu_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (hs),
        .enable (active),
        .tick   (tick)
    );

    // Error packets jump straight to the last frame slot so they reuse the CMD frame path.
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        frame_n = frame_cnt;
        case (state)
            IDLE: ;
            START:
                if (tick) state_n = TYPE;
            TYPE:
                if (tick) begin
                    state_n = PAYLOAD;
                    bit_n   = 3'd0;
                end
            PAYLOAD:
                if (tick) begin
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef MTM_SER_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
`ifdef MTM_SER_PARITY_EN
            PARITY:
                if (tick) state_n = STOP;
`endif
            STOP:
                if (tick) begin
                    if (frame_cnt == LAST_FRAME) begin
                        state_n = IDLE;
                    end else begin
                        state_n = START;
                        frame_n = frame_cnt + FW'(1);
                    end
                end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = START;
            bit_n   = 3'd0;
            frame_n = in_err ? LAST_FRAME : '0;
        end
    end

    // Line value for the coming cycle, derived from the next state so sout can be registered.
    always_comb begin
        cur_byte = 8'(pkt_q >> (8 * (DATA_BYTES - int'(frame_n))));
        cur_type = (frame_n == LAST_FRAME) ? TYPE_CMD : TYPE_DATA;
        case (state_n)
            START:   sout_n = BIT_START;
            TYPE:    sout_n = cur_type;
            PAYLOAD: sout_n = cur_byte[3'd7 - bit_n];
`ifdef MTM_SER_PARITY_EN
            PARITY:  sout_n = ^{cur_type, cur_byte};
`endif
            default: sout_n = BIT_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            pkt_q     <= '0;
            sout      <= BIT_STOP;
            drop      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_n;
            frame_cnt <= frame_n;
            if (hs) pkt_q <= {data_in, ctl_in};
            sout      <= sout_n;
            drop      <= hs && !in_legal;
        end
    end

endmodule

// File: tb/tb_mtm_alu_serializer_n.sv
// Directed bench for mtm_alu_serializer_n: one BIT_DIV=1 and one BIT_DIV=4 instance.
// Frame length follows MTM_SER_PARITY_EN.
module tb_mtm_alu_serializer_n;

    logic        clk = 1'b0;
    logic        reset1, reset4, in_valid1, in_valid4;
    logic [31:0] data_in;
    logic [7:0]  ctl_in;
    logic        in_ready1, sout1, busy1, drop1;
    logic        in_ready4, sout4, busy4, drop4;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    mtm_alu_serializer_n #(.DATA_BYTES(4), .BIT_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset1), .data_in(data_in), .ctl_in(ctl_in),
        .in_valid(in_valid1), .in_ready(in_ready1), .sout(sout1), .busy(busy1), .drop(drop1)
    );

    mtm_alu_serializer_n #(.DATA_BYTES(4), .BIT_DIV(4)) u_dut4 (
        .clk(clk), .reset(reset4), .data_in(data_in), .ctl_in(ctl_in),
        .in_valid(in_valid4), .in_ready(in_ready4), .sout(sout4), .busy(busy4), .drop(drop4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int sel, output logic so, output logic rdy,
                          output logic bs, output logic dr);
        if (sel != 0) begin
            so = sout4; rdy = in_ready4; bs = busy4; dr = drop4;
        end else begin
            so = sout1; rdy = in_ready1; bs = busy1; dr = drop1;
        end
    endtask

    task automatic set_valid(input int sel, input logic v);
        if (sel != 0) in_valid4 = v;
        else          in_valid1 = v;
    endtask

    task automatic add_frame(input logic t, input logic [7:0] b);
        exp_q.push_back(1'b0);
        exp_q.push_back(t);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
`ifdef MTM_SER_PARITY_EN
        exp_q.push_back(^{t, b});
`endif
        exp_q.push_back(1'b1);
    endtask

    task automatic add_data_pkt(input logic [31:0] d, input logic [7:0] c);
        for (int k = 3; k >= 0; k--) add_frame(1'b0, d[8*k +: 8]);
        add_frame(1'b1, c);
    endtask

    // Present a packet and take the handshake edge; in_valid is left high.
    task automatic start_pkt(input int sel, input logic [31:0] d, input logic [7:0] c);
        logic so, rdy, bs, dr;
        data_in = d;
        ctl_in  = c;
        set_valid(sel, 1'b1);
        sample(sel, so, rdy, bs, dr);
        chk("ready_before_pkt", rdy, 1'b1);
        step();
    endtask

    // Checks up to lim cycles of exp_q; first_bits marks the end of the first packet.
    task automatic run_stream(input int sel, input int first_bits, input int lim);
        logic so, rdy, bs, dr;
        int div, total, l1, n;
        div   = (sel != 0) ? 4 : 1;
        total = exp_q.size() * div;
        l1    = first_bits * div;
        n     = (lim < total) ? lim : total;
        for (int i = 0; i < n; i++) begin
            sample(sel, so, rdy, bs, dr);
            chk($sformatf("sout_c%0d", i), so, exp_q[i / div]);
            chk($sformatf("ready_c%0d", i), rdy, (i == l1 - 1) || (i == total - 1));
            chk($sformatf("busy_c%0d", i), bs, 1'b1);
            chk($sformatf("drop_c%0d", i), dr, 1'b0);
            step();
            if (i == l1 - 1) set_valid(sel, 1'b0);
        end
        exp_q.delete();
    endtask

    task automatic check_idle(input int sel, input string tag);
        logic so, rdy, bs, dr;
        sample(sel, so, rdy, bs, dr);
        chk({tag, "_sout"}, so, 1'b1);
        chk({tag, "_ready"}, rdy, 1'b1);
        chk({tag, "_busy"}, bs, 1'b0);
        chk({tag, "_drop"}, dr, 1'b0);
    endtask

    initial begin
        logic so, rdy, bs, dr;
        int   l1;

        reset1 = 1'b0; reset4 = 1'b0;
        in_valid1 = 1'b0; in_valid4 = 1'b0;
        data_in = '0; ctl_in = '0;
        step(); step();
        for (int s = 0; s < 2; s++) begin
            sample(s, so, rdy, bs, dr);
            chk("rst_sout", so, 1'b1);
            chk("rst_busy", bs, 1'b0);
            chk("rst_drop", dr, 1'b0);
            chk("rst_ready", rdy, 1'b0);
        end
        reset1 = 1'b1; reset4 = 1'b1;
        step();
        check_idle(0, "post_rst1");
        check_idle(1, "post_rst4");

        // DATA packet; inputs scrambled after the handshake must not leak into the line
        add_data_pkt(32'hF322ACAA, 8'h2A);
        start_pkt(0, 32'hF322ACAA, 8'h2A);
        set_valid(0, 1'b0);
        data_in = 32'h0DD5_3355;
        ctl_in  = 8'hFF;
        run_stream(0, exp_q.size(), 1000);
        check_idle(0, "after_data");

        // ERROR packet: single CMD-typed frame
        add_frame(1'b1, 8'hC9);
        start_pkt(0, 32'h1234_5678, 8'hC9);
        set_valid(0, 1'b0);
        run_stream(0, exp_q.size(), 1000);
        check_idle(0, "after_err");

        // Illegal CTLs are discarded with a one-cycle drop pulse
        for (int k = 0; k < 2; k++) begin
            ctl_in  = (k == 0) ? 8'h80 : 8'hC8;
            data_in = 32'hAAAA_5555;
            in_valid1 = 1'b1;
            step();
            in_valid1 = 1'b0;
            sample(0, so, rdy, bs, dr);
            chk("illegal_drop", dr, 1'b1);
            chk("illegal_sout", so, 1'b1);
            chk("illegal_busy", bs, 1'b0);
            chk("illegal_ready", rdy, 1'b1);
            step();
            check_idle(0, "illegal_after");
        end

        // Back-to-back: DATA then ERROR with in_valid held high
        add_data_pkt(32'h1234_5601, 8'h05);
        l1 = exp_q.size();
        add_frame(1'b1, 8'h93);
        start_pkt(0, 32'h1234_5601, 8'h05);
        data_in = 32'h0;
        ctl_in  = 8'h93;
        run_stream(0, l1, 1000);
        check_idle(0, "after_b2b");

        // BIT_DIV=4: reset 20 cycles into a packet, then a clean packet
        add_data_pkt(32'h2DAD_BEEF, 8'h11);
        start_pkt(1, 32'h2DAD_BEEF, 8'h11);
        set_valid(1, 1'b0);
        run_stream(1, exp_q.size(), 20);
        reset4 = 1'b0;
        step();
        sample(1, so, rdy, bs, dr);
        chk("midrst_sout", so, 1'b1);
        chk("midrst_busy", bs, 1'b0);
        chk("midrst_ready", rdy, 1'b0);
        chk("midrst_drop", dr, 1'b0);
        step();
        sample(1, so, rdy, bs, dr);
        chk("midrst_hold_sout", so, 1'b1);
        reset4 = 1'b1;
        step();
        check_idle(1, "midrst_release");

        add_data_pkt(32'h0055_AA0F, 8'h7F);
        start_pkt(1, 32'h0055_AA0F, 8'h7F);
        set_valid(1, 1'b0);
        run_stream(1, exp_q.size(), 10000);
        check_idle(1, "after_div4");

        // Payload byte 8'h01 and an all-ones byte exercise both parity senses
        add_data_pkt(32'h01FF_8000, 8'h01);
        start_pkt(0, 32'h01FF_8000, 8'h01);
        set_valid(0, 1'b0);
        run_stream(0, exp_q.size(), 1000);
        check_idle(0, "after_par");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
